// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

  // Stage-register control bundle: write enables then bubble flushes.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_fl;
    logic idex_fl;
    logic exmem_fl;
    logic memwb_fl;
  } ctl_t;

  localparam ctl_t CtlRun     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CtlStall   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t CtlBranch  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CtlLoadUse = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CtlReset   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign hazard_o = mem_read_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch flush and
// load-use stall, plus a saturating stall counter and sticky timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_Rt_i,
  input  logic [4:0]  IFID_Rs_i,
  input  logic [4:0]  IFID_Rt_i,
  input  logic        BranchTaken_i,
  input  logic        MemAccess_i,
  input  logic        MemReady_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IDEXWrite_o,
  output logic        EXMEMWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXFlush_o,
  output logic        EXMEMFlush_o,
  output logic        MEMWBFlush_o,
  output logic [15:0] StallCnt_o,
  output logic        MemErr_o
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;
  logic        load_use;
  ctl_t        run_ctl, ctl;

  load_use_detect u_load_use_detect (
    .mem_read_i (IDEX_MemRead_i),
    .ex_rt_i    (IDEX_Rt_i),
    .id_rs_i    (IFID_Rs_i),
    .id_rt_i    (IFID_Rt_i),
    .hazard_o   (load_use)
  );

  // Controls for a cycle with no memory stall; branch flush masks load-use.
  always_comb begin
    run_ctl = CtlRun;
    if (BranchTaken_i) begin
      run_ctl = CtlBranch;
    end else if (load_use) begin
      run_ctl = CtlLoadUse;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = run_ctl;
    case (state_q)
      StRun: begin
        if (MemAccess_i && !MemReady_i) begin
          ctl     = CtlStall;
          state_d = StMemWait;
          wait_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (!MemReady_i) begin
          ctl    = CtlStall;
          wait_d = wait_q + 8'd1;
          if (wait_q == WaitLast) begin
            state_d = StHalt;
          end
        end else begin
          state_d = StRun;
          wait_d  = 8'd0;
        end
      end
      StHalt: begin
        ctl = CtlStall;
      end
      default: begin
        state_d = StRun;
        wait_d  = 8'd0;
      end
    endcase
    // Reset forces all stage registers to hold bubbles regardless of the clock.
    if (!rst_n_i) begin
      ctl = CtlReset;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!ctl.pc_we && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    err_d = err_q | (state_d == StHalt);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      stall_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign PCWrite_o    = ctl.pc_we;
  assign IFIDWrite_o  = ctl.ifid_we;
  assign IDEXWrite_o  = ctl.idex_we;
  assign EXMEMWrite_o = ctl.exmem_we;
  assign IFIDFlush_o  = ctl.ifid_fl;
  assign IDEXFlush_o  = ctl.idex_fl;
  assign EXMEMFlush_o = ctl.exmem_fl;
  assign MEMWBFlush_o = ctl.memwb_fl;
  assign StallCnt_o   = stall_q;
  assign MemErr_o     = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

  localparam int Tmo = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        branch, mem_acc, mem_rdy;
  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
  logic [15:0] stall_cnt;
  logic        mem_err;

  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: halt flag, length of current memory wait, stall total.
  bit m_halted = 0;
  int m_consec = 0;
  int m_stall  = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(Tmo)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .IDEX_MemRead_i (mem_read),
    .IDEX_Rt_i      (ex_rt),
    .IFID_Rs_i      (id_rs),
    .IFID_Rt_i      (id_rt),
    .BranchTaken_i  (branch),
    .MemAccess_i    (mem_acc),
    .MemReady_i     (mem_rdy),
    .PCWrite_o      (pc_we),
    .IFIDWrite_o    (ifid_we),
    .IDEXWrite_o    (idex_we),
    .EXMEMWrite_o   (exmem_we),
    .IFIDFlush_o    (ifid_fl),
    .IDEXFlush_o    (idex_fl),
    .EXMEMFlush_o   (exmem_fl),
    .MEMWBFlush_o   (memwb_fl),
    .StallCnt_o     (stall_cnt),
    .MemErr_o       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    branch = 1'b0; mem_acc = 1'b0; mem_rdy = 1'b1;
  endtask

  task automatic cycle(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic acc,
                       input logic rdy);
    exp_t e;
    bit   stall;
    @(posedge clk); #1;
    mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    branch = br; mem_acc = acc; mem_rdy = rdy;
    if (m_halted) stall = 1;
    else if (m_consec > 0) stall = !rdy;
    else stall = acc && !rdy;
    e.cnt = 16'(m_stall);
    e.err = m_halted;
    if (stall) e.ctl = 8'b0000_0001;
    else if (br) e.ctl = 8'b1111_1110;
    else if (mr && ert != 0 && (ert == rs || ert == rt)) e.ctl = 8'b0011_0100;
    else e.ctl = 8'b1111_0000;
    sb.push_back(e);
    if (!e.ctl[7] && m_stall < 65535) m_stall++;
    if (!m_halted) begin
      if (stall) begin
        m_consec++;
        if (m_consec >= Tmo) m_halted = 1;
      end else begin
        m_consec = 0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asserts reset between clock edges so its effect is seen with no edge in between.
  task automatic do_reset();
    exp_t e;
    @(posedge clk); #2;
    rst_n = 1'b0;
    set_idle();
    e.ctl = 8'b0000_1111;
    e.cnt = 16'd0;
    e.err = 1'b0;
    sb.push_back(e);
    m_halted = 0; m_consec = 0; m_stall = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = {pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, exmem_fl, memwb_fl};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b want %b", $time, act, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.cnt);
      end
      checks++;
      if (mem_err !== e.err) begin
        errors++;
        $display("FAIL mem_err @%0t: got %b want %b", $time, mem_err, e.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    do_reset();
    idle();
    // Load-use stall, then counter shows one stall.
    cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    // Register-zero guard.
    cycle(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    // Branch beats load-use.
    cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    // Three-cycle memory wait, release on the fourth.
    repeat (3) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    // Timeout into halt; halt persists until reset.
    repeat (6) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (2) idle();
    do_reset();
    idle();
    // Reset in the middle of a memory wait.
    repeat (2) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 49) do_reset();
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, range 2..255: max MEMWAIT cycles before halt.
REQ-002 clk_i  in  1  sole clock; all state updates on posedge.
REQ-003 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-005 IDEX_Rt_i  in  5  load destination register in EX.
REQ-006 IFID_Rs_i, IFID_Rt_i  in  5 each  source registers of instruction in ID.
REQ-007 BranchTaken_i  in  1  branch in MEM resolved taken (EX/MEM Branch AND zero).
REQ-008 MemAccess_i  in  1  instruction in MEM reads or writes data memory.
REQ-009 MemReady_i  in  1  data memory completes the current access this cycle.
REQ-010 PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEMWrite_o  out  1 each  stage-register load enables.
REQ-011 IFIDFlush_o, IDEXFlush_o, EXMEMFlush_o, MEMWBFlush_o  out  1 each  load bubble (all controls 0) into that register.
REQ-012 StallCnt_o  out  16  count of cycles with PCWrite_o=0.
REQ-013 MemErr_o  out  1  sticky memory-timeout flag.

Function
REQ-014 FSM states RUN, MEMWAIT, HALT; outputs combinational from state and inputs (Mealy).
REQ-015 Default (RUN, no hazard): all write enables 1, all flushes 0.
REQ-016 Priority in RUN: memory wait > taken branch > load-use.
REQ-017 RUN, MemAccess_i=1, MemReady_i=0: all write enables 0, MEMWBFlush_o=1; next state MEMWAIT, wait counter <= 1.
REQ-018 RUN, BranchTaken_i=1 (no memory wait): PCWrite_o=1, IFIDFlush_o=IDEXFlush_o=EXMEMFlush_o=1, other writes 1; load-use suppressed.
REQ-019 Load-use: IDEX_MemRead_i=1, IDEX_Rt_i!=0, IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i -> PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1, EXMEMWrite_o=1; one cycle, no state change.
REQ-020 MEMWAIT, MemReady_i=0: outputs as REQ-017; wait counter +1; if counter = MEM_TIMEOUT-1, next HALT.
REQ-021 MEMWAIT, MemReady_i=1: outputs identical to RUN with the same inputs (branch/load-use rules apply); next RUN.
REQ-022 HALT: all write enables 0, MEMWBFlush_o=1, MemErr_o=1; leaves only via reset.
REQ-023 BranchTaken_i and MemAccess_i both 1 is illegal upstream; memory wait wins, branch re-evaluated after release (EX/MEM held).
REQ-024 StallCnt_o increments each cycle PCWrite_o=0, saturates at 16'hFFFF.
REQ-025 Wait counter 8 bits, cleared on entry to RUN.

Reset
REQ-026 rst_n_i low: state RUN, wait counter 0, StallCnt_o=0, MemErr_o=0, immediately and regardless of clock.
REQ-027 While rst_n_i low: all write enables 0, all flushes 1.
REQ-028 Reset during MEMWAIT or HALT aborts it; first cycle after release is RUN.

Structure
REQ-029 Shared package pipe_ctrl_pkg holds state enum, MEM_TIMEOUT default, REG_ZERO constant (5'd0).
REQ-030 One combinational sub-module load_use_detect (REQ-019 compare); FSM, counters, output mux in top.

Verification
REQ-031 Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=5, IFID_Rs_i=5 -> one cycle PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; StallCnt_o=1.
REQ-032 Rt=0 guard: IDEX_MemRead_i=1, IDEX_Rt_i=0, IFID_Rt_i=0 -> no stall, StallCnt_o unchanged.
REQ-033 Branch beats load-use: BranchTaken_i=1 with REQ-031 hazard -> PCWrite_o=1, three flushes 1, IDEXWrite_o=1.
REQ-034 Memory wait: MemAccess_i=1, MemReady_i=0 for 3 cycles then 1 -> writes 0 for 3 cycles, MEMWBFlush_o=1, release on 4th; StallCnt_o=3.
REQ-035 Timeout: MEM_TIMEOUT=4, MemReady_i held 0 -> HALT after 4 stall cycles, MemErr_o=1 persists; rst_n_i pulse clears to RUN.
REQ-036 Async reset mid-MEMWAIT, no clock edge -> outputs per REQ-027 at once; StallCnt_o=0.
